// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: line synchronizer, 11-bit deframer with idle
// timeout, and a small receive FIFO popped through an active-low strobe.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    clk_sync;
    logic [2:0]    dat_sync;
    logic          fall;
    logic          bit_in;

    logic [3:0]    cnt;
    logic [9:0]    shreg;
    logic [IW-1:0] idle;
    logic          frame_done;
    logic          frame_ok;
    logic          push;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = dat_sync[1];

    // shreg holds start in [0], d0..d7 in [8:1], parity in [9] when the stop bit arrives
    assign frame_done = fall & (cnt == 4'd10);
    assign frame_ok   = ~shreg[0] & bit_in & (^shreg[9:1]);
    assign push       = frame_done & frame_ok;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt       <= '0;
            shreg     <= '0;
            idle      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_done & ~frame_ok;
            if (fall) begin
                idle  <= '0;
                shreg <= {bit_in, shreg[9:1]};
                cnt   <= (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
            end else if (cnt != 4'd0) begin
                if (idle == IW'(TIMEOUT_CYC)) begin
                    cnt  <= '0;
                    idle <= '0;
                end else begin
                    idle <= idle + IW'(1);
                end
            end else begin
                idle <= '0;
            end
        end
    end

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign ready = ~empty;
    assign pop   = ~nextdata_n & ready;
    assign wr_en = push & (~full | pop);
    assign data  = ready ? mem[rp[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp[AW-1:0]] <= shreg[8:1];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wp <= wp + (AW+1)'(1);
            if (pop)   rp <= rp + (AW+1)'(1);
            if (pop)
                overflow <= 1'b0;
            else if (push && full)
                overflow <= 1'b1;
        end
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 device-to-host receiver with a small receive FIFO. It oversamples the raw `ps2_clk`/`ps2_data` lines on the system clock and deframes 11-bit PS/2 frames. Bytes from valid frames are queued for the scan-code decoder directly downstream, which pops them one byte at a time through an active-low `nextdata_n` strobe and assembles make/break/extended key codes.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `TIMEOUT_CYC`, 100000: idle `clk` cycles inside a frame before the partial frame is discarded (2 ms at 50 MHz).
- `clk` input 1: system clock; all state on its rising edge.
- `clrn` input 1: reset, asynchronous, active-low.
- `ps2_clk` input 1: raw PS/2 clock line, asynchronous.
- `ps2_data` input 1: raw PS/2 data line, asynchronous.
- `nextdata_n` input 1: pop request, active-low, sampled each `clk`.
- `data` output 8: FIFO head byte; valid while `ready`=1.
- `ready` output 1: FIFO non-empty.
- `overflow` output 1: sticky; a valid frame arrived while the FIFO was full.
- `frame_err` output 1: one-cycle pulse on a frame with bad start, stop or parity.

## Operation
- Synchronizer:
  - `ps2_clk` and `ps2_data` each pass through a 3-flop shift register.
  - A falling edge is detected when the two oldest `ps2_clk` flops read 1 then 0.
  - The data bit is taken from the matching-depth `ps2_data` flop in the same cycle.
- Deframer:
  - 4-bit bit counter `cnt` (0..10) and a 10-bit shift register.
  - Bit order: start (0), d0..d7 (LSB first), odd parity, stop (1).
  - Each detected falling edge shifts in one bit and increments `cnt`.
  - On the edge that carries bit 10 (stop), the frame is evaluated and `cnt` returns to 0.
- Frame check:
  - Valid frame: start==0, stop==1, and XOR of d0..d7 and parity ==1.
  - Valid frame: push the byte.
  - Invalid frame: pulse `frame_err` for 1 cycle; push nothing.
- Timeout:
  - When `cnt`≠0, an idle counter increments every cycle without an edge and clears on an edge.
  - When the idle counter reaches `TIMEOUT_CYC`, `cnt` returns to 0 and the partial frame is dropped silently; no `frame_err`.
  - Width of the idle counter: ceil(log2(TIMEOUT_CYC+1)).
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo 2·DEPTH.
  - Pop: `nextdata_n`==0 and `ready`==1 advances the read pointer by 1 in that cycle. Holding `nextdata_n` low pops one byte per cycle. A pop on an empty FIFO is ignored.
  - Push with FIFO not full: byte written at the write pointer.
  - Push with FIFO full and no pop in the same cycle: byte dropped, `overflow`←1.
  - Push and pop in the same cycle: both take effect, including when full (no overflow) and when empty+push (the pop is ignored; the byte remains).
  - `overflow` clears on the first successful pop after it was set, or on reset.
- Reset (`clrn`=0, any time including mid-frame):
  - `cnt`, idle counter and pointers←0; synchronizer flops←1 (idle line).
  - Outputs: `ready`=0, `overflow`=0, `frame_err`=0, `data`=8'h00. The FIFO RAM is not cleared; `data` is masked to 0 while empty.

## Timing
- Edge detect latency: a `ps2_clk` fall is detected 2–3 `clk` cycles after it occurs (synchronizer depth).
- Let E be the cycle in which the stop-bit edge is detected.
  - Write occurs at the end of E.
  - `ready`=1 and `data` valid from E+1.
  - `frame_err` is high during E+1 only.
- Pop:
  - `nextdata_n` low in cycle P with `ready`=1 → `data` shows the next entry in P+1.
  - `ready` falls in P+1 if that entry was the last.
- Throughput: one frame per 11 PS/2 clocks (~10–16.7 kHz line clock); the FIFO absorbs bursts of up to `DEPTH` bytes.
- No combinational path from `nextdata_n` to any output; all outputs are registered or derived from pointers and RAM only.

## Test plan
- Single frame: send 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1) → `ready`=1 at E+1 with `data`=8'h1C; pulse `nextdata_n` low for 1 cycle → `ready`=0 next cycle.
- Ordering: send 0xE0, 0xF0, 0x75 with no pops, then pop three times back-to-back → `data` sequence E0, F0, 75; `ready` drops after the third pop; no `frame_err`.
- Parity error: send 0x1C with parity=1 → `frame_err` high for exactly 1 cycle; `ready` stays 0. Following good frame 0x29 → `data`=8'h29.
- Overflow: send 9 valid frames 0x01..0x09 with no pops (`DEPTH`=8) → `overflow`=1; pops return 01..08 only; `overflow`=0 after the first pop.
- Timeout resync: send 5 bits of a frame, hold `ps2_clk` high for `TIMEOUT_CYC`+10 cycles, then send 0xF0 → exactly one byte, 8'hF0; no `frame_err`.
- Reset mid-operation: queue 2 bytes and start a third frame, assert `clrn`=0 for 3 cycles mid-frame, then send 0x5A → all outputs are 0 during reset; afterwards exactly one byte, 8'h5A.
